// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Constants assume a 100 MHz core clock.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_10MS = 1_000_000;
    localparam int LONG_1S       = 100_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button: 2-FF sync, counter debounce FSM, registered level and rise/fall/long pulses.
// Latency DEBOUNCE_CYCLES+2 cycles after sync capture; no backpressure, pulses are fire-and-forget.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
    parameter int LONG_PRESS_CYCLES = LONG_1S
) (
    input  logic CLK100MHZ,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic long_pulse
);

    localparam int CW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_PRESS_CYCLES - 1);

    logic          sync_ff1;
    logic          sync_ff2;
    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hold_cnt;
    logic          long_done;

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= btn;
            sync_ff2 <= sync_ff1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOW;
            cnt        <= '0;
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            long_pulse <= 1'b0;
            case (state)
                S_LOW: begin
                    if (sync_ff2) begin
                        state <= S_RISE_WAIT;
                        cnt   <= '0;
                    end
                end
                S_RISE_WAIT: begin
                    if (!sync_ff2) begin
                        state <= S_LOW;
                    end else if (cnt == DB_LAST) begin
                        state      <= S_HIGH;
                        level      <= 1'b1;
                        rise_pulse <= 1'b1;
                        cnt        <= '0;
                        hold_cnt   <= '0;
                        long_done  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    // hold_cnt survives a release bounce so long-press timing is not restarted
                    if (!sync_ff2) begin
                        state <= S_FALL_WAIT;
                        cnt   <= '0;
                    end else if (hold_cnt < HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (!long_done) begin
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                    end
                end
                S_FALL_WAIT: begin
                    if (sync_ff2) begin
                        state <= S_HIGH;
                    end else if (cnt == DB_LAST) begin
                        state      <= S_LOW;
                        level      <= 1'b0;
                        fall_pulse <= 1'b1;
                        cnt        <= '0;
                        hold_cnt   <= '0;
                        long_done  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_LOW;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent debounced button channels with level and rise/fall/long pulses.
// Latency DEBOUNCE_CYCLES+3 edges from first sampling edge; no backpressure.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN             = 4,
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
    parameter int LONG_PRESS_CYCLES = LONG_1S
) (
    input  logic             CLK100MHZ,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] rise_pulse,
    output logic [N_BTN-1:0] fall_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .CLK100MHZ (CLK100MHZ),
            .rst_n     (rst_n),
            .btn       (btn[g]),
            .level     (level[g]),
            .rise_pulse(rise_pulse[g]),
            .fall_pulse(fall_pulse[g]),
            .long_pulse(long_pulse[g])
        );
    end

endmodule
